// File: rtl/comp_serial_cmp.sv
// rtl/comp_serial_cmp.sv - digit-serial MSB-first magnitude comparator with valid/ready handshakes
// One D-bit digit per RUN cycle; the first differing digit fixes the ordering.
module comp_serial_cmp #(
    parameter int W          = 32,
    parameter int D          = 4,
    parameter int EARLY_EXIT = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         is_signed,
    input  logic [2:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         result,
    output logic         cmp_lt,
    output logic         cmp_eq
);

    localparam int N  = W / D;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [D-1:0] MSB_MASK = D'(1) << (D - 1);

    localparam logic [2:0] OP_LT = 3'd0;
    localparam logic [2:0] OP_LE = 3'd1;
    localparam logic [2:0] OP_GT = 3'd2;
    localparam logic [2:0] OP_GE = 3'd3;
    localparam logic [2:0] OP_EQ = 3'd4;
    localparam logic [2:0] OP_NE = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [2:0]      r_op;
    logic            r_signed;
    logic            r_decided;
    logic            r_lt;
    logic            r_out_valid;
    logic            r_result;
    logic            r_cmp_lt;
    logic            r_cmp_eq;

    logic            w_top;
    logic [D-1:0]    w_flip;
    logic [D-1:0]    w_da;
    logic [D-1:0]    w_db;
    logic            w_diff;
    logic            w_dec_next;
    logic            w_lt_next;
    logic            w_eq_next;
    logic            w_gt_next;
    logic            w_last;
    logic            w_result;

    // Operands are shifted left each step, so the current digit always sits at the top.
    assign w_top  = (r_cnt == CW'(N - 1));
    assign w_flip = (r_signed && w_top) ? MSB_MASK : '0;
    assign w_da   = r_a[W-1 -: D] ^ w_flip;
    assign w_db   = r_b[W-1 -: D] ^ w_flip;
    assign w_diff = (w_da != w_db);

    assign w_dec_next = r_decided | w_diff;
    assign w_lt_next  = r_decided ? r_lt : (w_da < w_db);
    assign w_eq_next  = ~w_dec_next;
    assign w_gt_next  = w_dec_next & ~w_lt_next;

    assign w_last = (r_cnt == '0) || ((EARLY_EXIT != 0) && w_dec_next);

    always_comb begin
        w_result = 1'b0;
        case (r_op)
            OP_LT:   w_result = w_lt_next;
            OP_LE:   w_result = w_lt_next | w_eq_next;
            OP_GT:   w_result = w_gt_next;
            OP_GE:   w_result = ~w_lt_next;
            OP_EQ:   w_result = w_eq_next;
            OP_NE:   w_result = ~w_eq_next;
            default: w_result = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_signed    <= 1'b0;
            r_decided   <= 1'b0;
            r_lt        <= 1'b0;
            r_out_valid <= 1'b0;
            r_result    <= 1'b0;
            r_cmp_lt    <= 1'b0;
            r_cmp_eq    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a       <= a;
                        r_b       <= b;
                        r_op      <= op;
                        r_signed  <= is_signed;
                        r_cnt     <= CW'(N - 1);
                        r_decided <= 1'b0;
                        r_lt      <= 1'b0;
                        r_state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_decided <= w_dec_next;
                    r_lt      <= w_lt_next;
                    r_a       <= r_a << D;
                    r_b       <= r_b << D;
                    if (w_last) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_result    <= w_result;
                        r_cmp_lt    <= w_lt_next;
                        r_cmp_eq    <= w_eq_next;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign cmp_lt    = r_cmp_lt;
    assign cmp_eq    = r_cmp_eq;

endmodule

// File: tb/tb_comp_serial_cmp.sv
// tb/tb_comp_serial_cmp.sv - self-checking bench for comp_serial_cmp over several W/D/EARLY_EXIT configs
// Eight instances share operand buses; each has its own handshake signals.
module tb_comp_serial_cmp;

    localparam int NG = 8;

    function automatic int w_of(input int g);
        return (g >= 6) ? 8 : 32;
    endfunction

    function automatic int d_of(input int g);
        case (g)
            0, 1:    return 1;
            2, 3:    return 4;
            4, 5:    return 32;
            default: return 2;
        endcase
    endfunction

    function automatic int ee_of(input int g);
        return g % 2;
    endfunction

    logic            clk = 1'b0;
    logic            rst_n;
    logic [31:0]     a_bus;
    logic [31:0]     b_bus;
    logic            sg;
    logic [2:0]      op;
    logic [NG-1:0]   iv;
    logic [NG-1:0]   ordy;
    logic [NG-1:0]   irdy;
    logic [NG-1:0]   ov;
    logic [NG-1:0]   res;
    logic [NG-1:0]   lt;
    logic [NG-1:0]   eq;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NG; g++) begin : g_dut
        localparam int GW = w_of(g);
        comp_serial_cmp #(
            .W(GW),
            .D(d_of(g)),
            .EARLY_EXIT(ee_of(g))
        ) u_dut (
            .clk(clk),
            .rst_n(rst_n),
            .in_valid(iv[g]),
            .in_ready(irdy[g]),
            .a(a_bus[GW-1:0]),
            .b(b_bus[GW-1:0]),
            .is_signed(sg),
            .op(op),
            .out_valid(ov[g]),
            .out_ready(ordy[g]),
            .result(res[g]),
            .cmp_lt(lt[g]),
            .cmp_eq(eq[g])
        );
    end

    int   tests = 0;
    int   fails = 0;
    int   obs_lat [NG];
    logic obs_res [NG];
    logic obs_lt  [NG];
    logic obs_eq  [NG];

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Reference: integer compare of the operands as numbers, latency from the highest differing bit.
    task automatic model(input int g, input logic [31:0] ta, input logic [31:0] tb,
                         input logic ts, input logic [2:0] to,
                         output logic r, output logic ol, output logic oe, output int lat);
        int     w;
        int     d;
        int     msb;
        longint m;
        longint va;
        longint vb;
        logic [31:0] x;
        w  = w_of(g);
        d  = d_of(g);
        m  = (longint'(1) << w) - 1;
        va = longint'(ta) & m;
        vb = longint'(tb) & m;
        if (ts && va[w-1]) va = va - (longint'(1) << w);
        if (ts && vb[w-1]) vb = vb - (longint'(1) << w);
        ol = (va < vb);
        oe = (va == vb);
        case (to)
            3'd0:    r = (va <  vb);
            3'd1:    r = (va <= vb);
            3'd2:    r = (va >  vb);
            3'd3:    r = (va >= vb);
            3'd4:    r = (va == vb);
            3'd5:    r = (va != vb);
            default: r = 1'b0;
        endcase
        lat = w / d + 1;
        if (ee_of(g) != 0 && !oe) begin
            x   = (ta ^ tb) & m[31:0];
            msb = -1;
            for (int i = 0; i < w; i++) if (x[i]) msb = i;
            lat = (w - 1 - msb) / d + 2;
        end
    endtask

    task automatic run_txn(input logic [NG-1:0] mask, input logic [31:0] ta, input logic [31:0] tb,
                           input logic ts, input logic [2:0] to);
        logic [NG-1:0] seen;
        int k;
        for (int g = 0; g < NG; g++) obs_lat[g] = -1;
        k = 0;
        @(negedge clk);
        while (((irdy & mask) != mask) && k < 50) begin
            @(negedge clk);
            k++;
        end
        a_bus = ta;
        b_bus = tb;
        sg    = ts;
        op    = to;
        iv    = mask;
        @(posedge clk);
        #1;
        iv    = '0;
        a_bus = $urandom;
        b_bus = $urandom;
        op    = 3'($urandom);
        sg    = 1'($urandom);
        seen  = '0;
        for (int c = 1; c <= 40 && ((seen & mask) != mask); c++) begin
            @(negedge clk);
            for (int g = 0; g < NG; g++) begin
                if (mask[g] && !seen[g] && ov[g]) begin
                    seen[g]    = 1'b1;
                    obs_lat[g] = c;
                    obs_res[g] = res[g];
                    obs_lt[g]  = lt[g];
                    obs_eq[g]  = eq[g];
                end
            end
        end
    endtask

    typedef struct {
        int          g;
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [2:0]  o;
        logic        er;
        logic        elt;
        logic        eeq;
        int          elat;
    } vec_t;

    vec_t vt [10];

    initial begin
        #800000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        mr, ml, me;
        int          mlat;
        logic [31:0] ra, rb;
        logic        rs;
        logic [2:0]  ro;
        logic        hr, hl, he;
        int          cnt;

        vt[0] = '{2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 9};
        vt[1] = '{2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 9};
        vt[2] = '{3, 32'h8000_0000, 32'h8000_0000, 1'b1, 3'd4, 1'b1, 1'b0, 1'b1, 9};
        vt[3] = '{3, 32'h7000_0000, 32'h1000_0000, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 2};
        vt[4] = '{3, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 3'd1, 1'b1, 1'b1, 1'b0, 2};
        vt[5] = '{3, 32'h1234_5678, 32'h1234_5679, 1'b0, 3'd5, 1'b1, 1'b1, 1'b0, 9};
        vt[6] = '{2, 32'h0000_0001, 32'h0000_0002, 1'b0, 3'd6, 1'b0, 1'b1, 1'b0, 9};
        vt[7] = '{5, 32'h0000_0005, 32'h0000_0005, 1'b0, 3'd1, 1'b1, 1'b0, 1'b1, 2};
        vt[8] = '{1, 32'h0000_0002, 32'h0000_0003, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 33};
        vt[9] = '{7, 32'h0000_0080, 32'h0000_007F, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 2};

        rst_n = 1'b0;
        iv    = '0;
        ordy  = '1;
        a_bus = '0;
        b_bus = '0;
        sg    = 1'b0;
        op    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", ov, 0);
        chk("reset_result", res, 0);
        chk("reset_cmp_lt", lt, 0);
        chk("reset_cmp_eq", eq, 0);
        chk("reset_in_ready", irdy, 8'hFF);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_txn(NG'(1) << vt[i].g, vt[i].a, vt[i].b, vt[i].s, vt[i].o);
            chk($sformatf("vec%0d_result", i), obs_res[vt[i].g], vt[i].er);
            chk($sformatf("vec%0d_cmp_lt", i), obs_lt[vt[i].g], vt[i].elt);
            chk($sformatf("vec%0d_cmp_eq", i), obs_eq[vt[i].g], vt[i].eeq);
            chk($sformatf("vec%0d_latency", i), obs_lat[vt[i].g], vt[i].elat);
        end

        // Backpressure: hold out_ready low on the (32,4) fixed-latency instance.
        ordy[2] = 1'b0;
        run_txn(NG'(4), 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 3'd0);
        chk("bp_latency", obs_lat[2], 9);
        hr = res[2];
        hl = lt[2];
        he = eq[2];
        chk("bp_result", hr, 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            a_bus = $urandom;
            b_bus = $urandom;
            iv[2] = c[0];
            chk($sformatf("bp_hold%0d_valid", c), ov[2], 1);
            chk($sformatf("bp_hold%0d_in_ready", c), irdy[2], 0);
            chk($sformatf("bp_hold%0d_outs", c), {res[2], lt[2], eq[2]}, {hr, hl, he});
        end
        iv[2]   = 1'b0;
        ordy[2] = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", ov[2], 0);
        chk("bp_release_in_ready", irdy[2], 1);
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (ov[2] || !irdy[2]) cnt++;
        end
        chk("bp_no_spurious", cnt, 0);

        // Reset in cycle 4 of a compare aborts it with no result.
        @(negedge clk);
        a_bus = 32'h0000_0001;
        b_bus = 32'h0000_0002;
        sg    = 1'b0;
        op    = 3'd0;
        iv    = NG'(4);
        @(posedge clk);
        #1;
        iv = '0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_out_valid", ov[2], 0);
        chk("rst_mid_in_ready", irdy[2], 1);
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (ov[2]) cnt++;
        end
        chk("rst_mid_no_result", cnt, 0);
        run_txn(NG'(4), 32'h0000_0010, 32'h0000_0020, 1'b0, 3'd0);
        chk("rst_fresh_result", obs_res[2], 1);
        chk("rst_fresh_latency", obs_lat[2], 9);

        for (int it = 0; it < 200; it++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = $urandom;
                1:       rb = ra;
                2:       rb = ra ^ (32'd1 << $urandom_range(0, 31));
                default: rb = ra ^ (32'($urandom) & 32'h0000_000F);
            endcase
            rs = 1'($urandom);
            ro = 3'($urandom);
            run_txn('1, ra, rb, rs, ro);
            for (int g = 0; g < NG; g++) begin
                model(g, ra, rb, rs, ro, mr, ml, me, mlat);
                chk($sformatf("rnd%0d_g%0d_result a=%h b=%h s=%0d op=%0d", it, g, ra, rb, rs, ro), obs_res[g], mr);
                chk($sformatf("rnd%0d_g%0d_cmp_lt", it, g), obs_lt[g], ml);
                chk($sformatf("rnd%0d_g%0d_cmp_eq", it, g), obs_eq[g], me);
                chk($sformatf("rnd%0d_g%0d_latency", it, g), obs_lat[g], mlat);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
